// File: rtl/mem_arbiter24.sv
// Arbiter for one single-port synchronous memory shared by the CPU fetch (I) and load/store (D) ports.
// Optional build macro MEMARB_ROUND_ROBIN_EN swaps D-priority/starvation guard for round-robin on ties.
module mem_arbiter24 #(
   parameter int unsigned DATA_W     = 24,
   parameter int unsigned ADDR_W     = 16,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              IReq,
   input  logic [ADDR_W-1:0] IAddr,
   output logic              IGnt,
   output logic [DATA_W-1:0] IRdata,
   output logic              IRvalid,
   input  logic              DReq,
   input  logic              DWe,
   input  logic [ADDR_W-1:0] DAddr,
   input  logic [DATA_W-1:0] DWdata,
   output logic              DGnt,
   output logic [DATA_W-1:0] DRdata,
   output logic              DRvalid,
   output logic              MemEn,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [DATA_W-1:0] MemWdata,
   input  logic [DATA_W-1:0] MemRdata,
   output logic              Busy
);

   localparam int unsigned LAT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   state_t            state_q, state_nx;
   logic [LAT_W-1:0]  lat_q, lat_nx;
   logic              owner_d_q, owner_d_nx;
   logic              gnt_i_c, gnt_d_c, done_c, i_pri_c;

   logic              ignt_nx, dgnt_nx, irvalid_nx, drvalid_nx;
   logic              memen_nx, memwe_nx, busy_nx;
   logic [ADDR_W-1:0] memaddr_nx;
   logic [DATA_W-1:0] memwdata_nx, irdata_nx, drdata_nx;

`ifdef MEMARB_ROUND_ROBIN_EN
   logic              last_d_q, last_d_nx;
`else
   localparam int unsigned STV_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   logic [STV_W-1:0]  starve_q, starve_nx;
`endif

   // State register and registered outputs
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q   <= IDLE;
         lat_q     <= '0;
         owner_d_q <= 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
         last_d_q  <= 1'b0;
`else
         starve_q  <= '0;
`endif
         IGnt      <= 1'b0;
         DGnt      <= 1'b0;
         IRvalid   <= 1'b0;
         DRvalid   <= 1'b0;
         IRdata    <= '0;
         DRdata    <= '0;
         MemEn     <= 1'b0;
         MemWe     <= 1'b0;
         MemAddr   <= '0;
         MemWdata  <= '0;
         Busy      <= 1'b0;
      end else begin
         state_q   <= state_nx;
         lat_q     <= lat_nx;
         owner_d_q <= owner_d_nx;
`ifdef MEMARB_ROUND_ROBIN_EN
         last_d_q  <= last_d_nx;
`else
         starve_q  <= starve_nx;
`endif
         IGnt      <= ignt_nx;
         DGnt      <= dgnt_nx;
         IRvalid   <= irvalid_nx;
         DRvalid   <= drvalid_nx;
         IRdata    <= irdata_nx;
         DRdata    <= drdata_nx;
         MemEn     <= memen_nx;
         MemWe     <= memwe_nx;
         MemAddr   <= memaddr_nx;
         MemWdata  <= memwdata_nx;
         Busy      <= busy_nx;
      end
   end

   // Arbitration, latency countdown and next state
   always_comb begin
      state_nx   = state_q;
      lat_nx     = lat_q;
      owner_d_nx = owner_d_q;
      gnt_i_c    = 1'b0;
      gnt_d_c    = 1'b0;
      done_c     = 1'b0;
`ifdef MEMARB_ROUND_ROBIN_EN
      last_d_nx  = last_d_q;
      i_pri_c    = last_d_q;
`else
      starve_nx  = starve_q;
      i_pri_c    = (starve_q == STV_W'(STARVE_MAX));
`endif
      case (state_q)
         IDLE: begin
            if (DReq && !(IReq && i_pri_c)) begin
               gnt_d_c = 1'b1;
            end else if (IReq) begin
               gnt_i_c = 1'b1;
            end
            if (gnt_i_c || gnt_d_c) begin
               owner_d_nx = gnt_d_c;
            end
            if (gnt_i_c || (gnt_d_c && !DWe)) begin
               state_nx = RD_WAIT;
               lat_nx   = LAT_W'(MEM_LAT);
            end
         end
         RD_WAIT: begin
            // Counter hits zero in the cycle MemRdata is valid
            if (lat_q == '0) begin
               done_c   = 1'b1;
               state_nx = IDLE;
            end else begin
               lat_nx = lat_q - LAT_W'(1);
            end
         end
         default: state_nx = IDLE;
      endcase
`ifdef MEMARB_ROUND_ROBIN_EN
      if (gnt_i_c || gnt_d_c) begin
         last_d_nx = gnt_d_c;
      end
`else
      if (!IReq || gnt_i_c) begin
         starve_nx = '0;
      end else if (gnt_d_c && (starve_q != STV_W'(STARVE_MAX))) begin
         starve_nx = starve_q + STV_W'(1);
      end
`endif
   end

   // Next values of the registered outputs
   always_comb begin
      ignt_nx     = gnt_i_c;
      dgnt_nx     = gnt_d_c;
      memen_nx    = gnt_i_c | gnt_d_c;
      memwe_nx    = gnt_d_c & DWe;
      memaddr_nx  = '0;
      memwdata_nx = '0;
      if (gnt_d_c) begin
         memaddr_nx = DAddr;
         if (DWe) begin
            memwdata_nx = DWdata;
         end
      end else if (gnt_i_c) begin
         memaddr_nx = IAddr;
      end
      irvalid_nx = done_c & ~owner_d_q;
      drvalid_nx = done_c & owner_d_q;
      irdata_nx  = irvalid_nx ? MemRdata : IRdata;
      drdata_nx  = drvalid_nx ? MemRdata : DRdata;
      busy_nx    = (state_nx == RD_WAIT);
   end

endmodule
